// File: rtl/lc3b_mem_pkg.sv
// Shared types and encodings for the LC-3b memory initiator.
package lc3b_mem_pkg;

    typedef enum logic [2:0] {
        IDLE,
        MAR,
        MDR,
        WAIT,
        DONE
    } state_t;

    localparam logic SIZE_BYTE = 1'b1;
    localparam logic SIZE_WORD = 1'b0;
    localparam logic RW_WRITE  = 1'b1;

endpackage

// File: rtl/mem_timeout_ctr.sv
// Loadable down-counter that bounds the wait for memory-ready.
module mem_timeout_ctr #(
    parameter int WIDTH = 5
) (
    input  logic             clk_50,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_dec,
    input  logic [WIDTH-1:0] i_load_val,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk_50 or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/mem_initiator.sv
// Requesting side of the MAR/MDR/R handshake: one load or store at a time,
// all outputs registered so nothing combinational reaches the bus from r.
//
// state | meaning
// IDLE  | accepting a request
// MAR   | ldMar strobe, address on bus_out
// MDR   | ldMdr strobe, store data on bus_out (stores only)
// WAIT  | waiting for r, bounded by the timeout counter
// DONE  | resp_valid pulse, then back to IDLE
module mem_initiator
    import lc3b_mem_pkg::*;
#(
    parameter int TIMEOUT = 32
) (
    input  logic        clk_50,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic        req_byte,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        resp_valid,
    output logic [15:0] resp_data,
    output logic        resp_err,
    output logic [15:0] bus_out,
    output logic        ldMar,
    output logic        ldMdr,
    output logic        rw,
    output logic        datasize,
    input  logic        r,
    input  logic [15:0] mdr_in
);

    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] LOAD_VAL = CW'(TIMEOUT - 1);

    state_t      r_state;
    logic        r_req_ready;
    logic        r_resp_valid;
    logic [15:0] r_resp_data;
    logic        r_resp_err;
    logic [15:0] r_bus_out;
    logic        r_ld_mar;
    logic        r_ld_mdr;
    logic        r_rw;
    logic        r_datasize;
    logic [15:0] r_wdata;
    logic        r_write;
    logic        r_byte;

    logic w_ctr_load;
    logic w_ctr_dec;
    logic w_ctr_zero;

    // Reload on the last cycle before WAIT so WAIT starts at TIMEOUT-1.
    assign w_ctr_load = ((r_state == MAR) && !r_write) || (r_state == MDR);
    assign w_ctr_dec  = (r_state == WAIT);

    mem_timeout_ctr #(
        .WIDTH (CW)
    ) u_timeout (
        .clk_50     (clk_50),
        .rst        (rst),
        .i_load     (w_ctr_load),
        .i_dec      (w_ctr_dec),
        .i_load_val (LOAD_VAL),
        .o_zero     (w_ctr_zero)
    );

    always_ff @(posedge clk_50 or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_data  <= 16'h0000;
            r_resp_err   <= 1'b0;
            r_bus_out    <= 16'h0000;
            r_ld_mar     <= 1'b0;
            r_ld_mdr     <= 1'b0;
            r_rw         <= 1'b0;
            r_datasize   <= 1'b0;
            r_wdata      <= 16'h0000;
            r_write      <= 1'b0;
            r_byte       <= 1'b0;
        end else begin
            r_ld_mar     <= 1'b0;
            r_ld_mdr     <= 1'b0;
            r_resp_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_wdata     <= req_wdata;
                        r_write     <= req_write;
                        r_byte      <= req_byte;
                        r_req_ready <= 1'b0;
                        r_resp_data <= 16'h0000;
                        if (!req_byte && req_addr[0]) begin
                            r_state      <= DONE;
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                        end else begin
                            r_state    <= MAR;
                            r_ld_mar   <= 1'b1;
                            r_bus_out  <= req_addr;
                            r_rw       <= req_write ? RW_WRITE : ~RW_WRITE;
                            r_datasize <= req_byte ? SIZE_BYTE : SIZE_WORD;
                            r_resp_err <= 1'b0;
                        end
                    end
                end
                MAR: begin
                    if (r_write) begin
                        r_state   <= MDR;
                        r_ld_mdr  <= 1'b1;
                        r_bus_out <= r_byte ? {8'h00, r_wdata[7:0]} : r_wdata;
                    end else begin
                        r_state <= WAIT;
                    end
                end
                MDR: begin
                    r_state <= WAIT;
                end
                WAIT: begin
                    // Ready takes priority over an expiring counter.
                    if (r) begin
                        r_state      <= DONE;
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= 1'b0;
                        r_resp_data  <= r_write ? 16'h0000 : mdr_in;
                        r_rw         <= 1'b0;
                    end else if (w_ctr_zero) begin
                        r_state      <= DONE;
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= 1'b1;
                        r_resp_data  <= 16'h0000;
                        r_rw         <= 1'b0;
                    end
                end
                DONE: begin
                    r_state     <= IDLE;
                    r_req_ready <= 1'b1;
                    r_rw        <= 1'b0;
                    r_datasize  <= 1'b0;
                end
                default: begin
                    r_state     <= IDLE;
                    r_req_ready <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready  = r_req_ready;
    assign resp_valid = r_resp_valid;
    assign resp_data  = r_resp_data;
    assign resp_err   = r_resp_err;
    assign bus_out    = r_bus_out;
    assign ldMar      = r_ld_mar;
    assign ldMdr      = r_ld_mdr;
    assign rw         = r_rw;
    assign datasize   = r_datasize;

endmodule

// File: tb/tb_mem_initiator.sv
// Directed self-checking bench for mem_initiator (TIMEOUT = 8).
module tb_mem_initiator;

    logic        clk_50;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic        req_byte;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        resp_valid;
    logic [15:0] resp_data;
    logic        resp_err;
    logic [15:0] bus_out;
    logic        ldMar;
    logic        ldMdr;
    logic        rw;
    logic        datasize;
    logic        r;
    logic [15:0] mdr_in;

    int n_pass;
    int n_total;

    // Observations from the most recent access.
    int          a_nmar, a_marcyc, a_nmdr, a_mdrcyc, a_respcyc;
    logic [15:0] a_marbus, a_mdrbus, a_data;
    logic        a_marrw, a_mards, a_err, a_resprw, a_rwhold, a_ready_after, a_acc_ready;

    mem_initiator #(.TIMEOUT(8)) dut (
        .clk_50     (clk_50),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_byte   (req_byte),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .resp_err   (resp_err),
        .bus_out    (bus_out),
        .ldMar      (ldMar),
        .ldMdr      (ldMdr),
        .rw         (rw),
        .datasize   (datasize),
        .r          (r),
        .mdr_in     (mdr_in)
    );

    initial clk_50 = 1'b0;
    always #5 clk_50 = ~clk_50;

    // Starts at a negedge with the DUT idle; presents the request in that
    // cycle (cycle 0). Memory raises r after n_low cycles of WAIT (n_low < 0:
    // never). If poke, a foreign request is shown in cycle 3.
    task automatic do_access(input logic wr, input logic by, input logic [15:0] addr,
                             input logic [15:0] wd, input int n_low,
                             input logic [15:0] mdr, input logic poke);
        int ws;
        ws = wr ? 3 : 2;
        a_nmar = 0; a_nmdr = 0; a_marcyc = -1; a_mdrcyc = -1; a_respcyc = -1;
        a_marbus = 16'hxxxx; a_mdrbus = 16'hxxxx; a_data = 16'hxxxx;
        a_marrw = 1'bx; a_mards = 1'bx; a_err = 1'bx; a_resprw = 1'bx;
        a_rwhold = 1'b1; a_ready_after = 1'b0;
        a_acc_ready = req_ready;
        req_valid = 1'b1; req_write = wr; req_byte = by;
        req_addr = addr; req_wdata = wd; r = 1'b0; mdr_in = mdr;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk_50);
            if (a_respcyc >= 0 && c == a_respcyc + 1) begin
                a_ready_after = req_ready;
                break;
            end
            if (ldMar) begin
                a_nmar++; a_marcyc = c; a_marbus = bus_out; a_marrw = rw; a_mards = datasize;
            end
            if (ldMdr) begin
                a_nmdr++; a_mdrcyc = c; a_mdrbus = bus_out;
            end
            if (resp_valid && a_respcyc < 0) begin
                a_respcyc = c; a_data = resp_data; a_err = resp_err; a_resprw = rw;
            end else if (a_respcyc < 0 && rw !== wr) begin
                a_rwhold = 1'b0;
            end
            req_valid = poke && (c == 3);
            req_addr  = (poke && c == 3) ? 16'h0100 : addr;
            req_write = (poke && c == 3) ? 1'b0 : wr;
            r = (n_low >= 0) && (c >= ws + n_low);
        end
        req_valid = 1'b0;
        r = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_byte = 1'b0;
        req_addr = 16'h0000; req_wdata = 16'h0000; r = 1'b0; mdr_in = 16'h0000;
        #2;
        n_total++;
        if ({req_ready, resp_valid, resp_err, ldMar, ldMdr, rw, datasize} !== 7'b1000000)
            $display("FAIL reset_ctrl: got %b want 1000000",
                     {req_ready, resp_valid, resp_err, ldMar, ldMdr, rw, datasize});
        else n_pass++;
        n_total++;
        if ({bus_out, resp_data} !== 32'h0)
            $display("FAIL reset_data: got bus=%h data=%h want 0", bus_out, resp_data);
        else n_pass++;
        repeat (2) @(negedge clk_50);
        rst = 1'b0;
        @(negedge clk_50);
        n_total++;
        if (req_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", req_ready);
        else n_pass++;
    endtask

    task automatic test_word_load();
        do_access(1'b0, 1'b0, 16'h0010, 16'h0000, 5, 16'h1234, 1'b1);
        n_total++;
        if ({a_nmar, a_nmdr} !== {32'd1, 32'd0})
            $display("FAIL wl_strobes: got mar=%0d mdr=%0d want 1/0", a_nmar, a_nmdr);
        else n_pass++;
        n_total++;
        if ({a_marbus, a_marrw, a_mards} !== {16'h0010, 1'b0, 1'b0})
            $display("FAIL wl_mar: got bus=%h rw=%b ds=%b want 0010/0/0", a_marbus, a_marrw, a_mards);
        else n_pass++;
        n_total++;
        if (a_respcyc !== 8) $display("FAIL wl_latency: got %0d want 8", a_respcyc);
        else n_pass++;
        n_total++;
        if ({a_data, a_err} !== {16'h1234, 1'b0})
            $display("FAIL wl_resp: got data=%h err=%b want 1234/0", a_data, a_err);
        else n_pass++;
        n_total++;
        if (a_ready_after !== 1'b1) $display("FAIL wl_ready_after: got %b want 1", a_ready_after);
        else n_pass++;
    endtask

    task automatic test_word_store();
        do_access(1'b1, 1'b0, 16'h0020, 16'hBEEF, 0, 16'h5A5A, 1'b0);
        n_total++;
        if ({a_marcyc, a_mdrcyc} !== {32'd1, 32'd2})
            $display("FAIL ws_order: got mar@%0d mdr@%0d want 1/2", a_marcyc, a_mdrcyc);
        else n_pass++;
        n_total++;
        if ({a_marbus, a_mdrbus} !== {16'h0020, 16'hBEEF})
            $display("FAIL ws_bus: got %h/%h want 0020/beef", a_marbus, a_mdrbus);
        else n_pass++;
        n_total++;
        if (a_rwhold !== 1'b1) $display("FAIL ws_rw_hold: got %b want 1", a_rwhold);
        else n_pass++;
        n_total++;
        if ({a_respcyc, a_data, a_err, a_resprw} !== {32'd4, 16'h0000, 1'b0, 1'b0})
            $display("FAIL ws_resp: got cyc=%0d data=%h err=%b rw=%b want 4/0000/0/0",
                     a_respcyc, a_data, a_err, a_resprw);
        else n_pass++;
    endtask

    task automatic test_byte_access();
        do_access(1'b1, 1'b1, 16'h0021, 16'hAB7F, 1, 16'h0000, 1'b0);
        n_total++;
        if ({a_mards, a_mdrbus} !== {1'b1, 16'h007F})
            $display("FAIL bs_bus: got ds=%b mdr=%h want 1/007f", a_mards, a_mdrbus);
        else n_pass++;
        n_total++;
        if ({a_respcyc, a_err} !== {32'd5, 1'b0})
            $display("FAIL bs_resp: got cyc=%0d err=%b want 5/0", a_respcyc, a_err);
        else n_pass++;
        do_access(1'b0, 1'b1, 16'h0033, 16'h0000, 2, 16'hFF80, 1'b0);
        n_total++;
        if ({a_mards, a_marbus, a_data, a_err, a_respcyc} !== {1'b1, 16'h0033, 16'hFF80, 1'b0, 32'd5})
            $display("FAIL bl_resp: got ds=%b bus=%h data=%h err=%b cyc=%0d want 1/0033/ff80/0/5",
                     a_mards, a_marbus, a_data, a_err, a_respcyc);
        else n_pass++;
    endtask

    task automatic test_unaligned();
        do_access(1'b0, 1'b0, 16'h0013, 16'h0000, 0, 16'h7777, 1'b0);
        n_total++;
        if ({a_nmar, a_nmdr} !== {32'd0, 32'd0})
            $display("FAIL ua_strobes: got mar=%0d mdr=%0d want 0/0", a_nmar, a_nmdr);
        else n_pass++;
        n_total++;
        if ({a_respcyc, a_err, a_data} !== {32'd1, 1'b1, 16'h0000})
            $display("FAIL ua_resp: got cyc=%0d err=%b data=%h want 1/1/0000", a_respcyc, a_err, a_data);
        else n_pass++;
    endtask

    task automatic test_timeout();
        do_access(1'b0, 1'b0, 16'h0040, 16'h0000, -1, 16'h1111, 1'b0);
        n_total++;
        if ({a_respcyc, a_err, a_data} !== {32'd10, 1'b1, 16'h0000})
            $display("FAIL to_resp: got cyc=%0d err=%b data=%h want 10/1/0000", a_respcyc, a_err, a_data);
        else n_pass++;
        // r arrives exactly as the counter reaches zero.
        do_access(1'b0, 1'b0, 16'h0042, 16'h0000, 7, 16'h2468, 1'b0);
        n_total++;
        if ({a_respcyc, a_err, a_data} !== {32'd10, 1'b0, 16'h2468})
            $display("FAIL to_edge: got cyc=%0d err=%b data=%h want 10/0/2468", a_respcyc, a_err, a_data);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        do_access(1'b0, 1'b0, 16'h0050, 16'h0000, 0, 16'hA001, 1'b0);
        n_total++;
        if ({a_respcyc, a_data} !== {32'd3, 16'hA001})
            $display("FAIL b2b_first: got cyc=%0d data=%h want 3/a001", a_respcyc, a_data);
        else n_pass++;
        do_access(1'b1, 1'b0, 16'h0052, 16'hC0DE, 0, 16'h0000, 1'b0);
        n_total++;
        if ({a_acc_ready, a_mdrbus, a_respcyc, a_err} !== {1'b1, 16'hC0DE, 32'd4, 1'b0})
            $display("FAIL b2b_second: got rdy=%b mdr=%h cyc=%0d err=%b want 1/c0de/4/0",
                     a_acc_ready, a_mdrbus, a_respcyc, a_err);
        else n_pass++;
    endtask

    task automatic test_r_idle();
        logic seen;
        seen = 1'b0;
        r = 1'b1;
        repeat (4) begin
            @(negedge clk_50);
            if (resp_valid || ldMar || ldMdr) seen = 1'b1;
        end
        r = 1'b0;
        n_total++;
        if (seen !== 1'b0) $display("FAIL r_idle: got activity=%b want 0", seen);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic seen;
        req_valid = 1'b1; req_write = 1'b1; req_byte = 1'b0;
        req_addr = 16'h0060; req_wdata = 16'h5555; r = 1'b0;
        @(negedge clk_50);
        req_valid = 1'b0;
        repeat (3) @(negedge clk_50);
        n_total++;
        if (rw !== 1'b1) $display("FAIL rm_pre_rw: got %b want 1", rw);
        else n_pass++;
        #1 rst = 1'b1;
        #1;
        n_total++;
        if ({ldMar, ldMdr, rw, datasize, resp_valid, req_ready} !== 6'b000001)
            $display("FAIL rm_drop: got %b want 000001",
                     {ldMar, ldMdr, rw, datasize, resp_valid, req_ready});
        else n_pass++;
        seen = 1'b0;
        @(negedge clk_50);
        @(negedge clk_50);
        rst = 1'b0;
        repeat (12) begin
            @(negedge clk_50);
            if (resp_valid) seen = 1'b1;
        end
        n_total++;
        if ({seen, req_ready} !== 2'b01)
            $display("FAIL rm_after: got valid_seen=%b ready=%b want 0/1", seen, req_ready);
        else n_pass++;
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        test_reset();
        test_word_load();
        test_word_store();
        test_byte_access();
        test_unaligned();
        test_timeout();
        test_back_to_back();
        test_r_idle();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_initiator.md
# mem_initiator

Memory-access initiator for the LC-3b datapath: the requesting end of the MAR/MDR/R memory handshake. It accepts one load or store request at a time (byte or word), sequences `ldMar`, `ldMdr`, `rw` and `datasize` toward the memory array, waits for the memory-ready `r`, and returns read data or completion status to the microsequencer. It sits between the control store/datapath and the memory block, replacing hand-driven MAR/MDR control strobes.

## Interface
Parameters:
- `TIMEOUT`, 32: maximum cycles spent waiting for `r` before the access is aborted with an error; legal range 8..255.

Ports:
- `clk_50` in 1: system clock, all logic on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: block idle and accepting a request.
- `req_write` in 1: 1 = store, 0 = load.
- `req_byte` in 1: 1 = byte access (LDB/STB), 0 = word (LDW/STW).
- `req_addr` in 16: byte address.
- `req_wdata` in 16: store data; bits [7:0] only for byte stores.
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_data` out 16: load result; 0 for stores and errors.
- `resp_err` out 1: qualifies `resp_valid`; 1 = unaligned or timeout.
- `bus_out` out 16: value driven onto the memory input bus.
- `ldMar` out 1: MAR load strobe.
- `ldMdr` out 1: MDR load strobe.
- `rw` out 1: 1 = write cycle.
- `datasize` out 1: 1 = byte, 0 = word.
- `r` in 1: memory-ready from memory array.
- `mdr_in` in 16: memory MDR contents; byte loads arrive already sign-extended.

## Operation
- States: IDLE, MAR, MDR, WAIT, DONE.
- IDLE: `req_ready`=1. On `req_valid`, capture addr/wdata/write/byte.
  - Word access with `req_addr[0]`=1: unaligned; go straight to DONE with `resp_err`=1. No strobe is issued.
  - Otherwise go to MAR.
- MAR, one cycle: `ldMar`=1 and `bus_out`=addr. Next state is MDR if write, else WAIT.
- MDR, one cycle (writes only): `ldMdr`=1. `bus_out` is:
  - word: wdata;
  - byte: {8'h00, wdata[7:0]}.
- WAIT:
  - `rw` and `datasize` are held steady for the whole state. They are driven from MAR entry through DONE.
  - The timeout counter is loaded with TIMEOUT-1 on WAIT entry and decrements each cycle.
  - `r`=1: capture `mdr_in` on loads and go to DONE with err=0.
  - Counter reaches 0 with `r`=0: go to DONE with err=1.
- DONE, one cycle:
  - `resp_valid`=1 with registered `resp_data`/`resp_err`.
  - `rw` returns to 0 and all strobes are 0.
  - Return to IDLE.
- Requests arriving while `req_ready`=0 are ignored; the requester holds `req_valid`.
- `r` arriving in the same cycle the counter hits 0: success wins.
- `r` asserted outside WAIT is ignored.

## Timing
- Reset values:
  - `req_ready`=1 once out of reset.
  - `resp_valid`=0, `resp_data`=0, `resp_err`=0.
  - `bus_out`=0, `ldMar`=0, `ldMdr`=0, `rw`=0, `datasize`=0.
  - State = IDLE, counter = 0.
- `rst` mid-access: immediate return to IDLE with all strobes low. No response pulse is generated.
- Outputs are all registered; no combinational path from `r` to any output.
- Load latency, from the accept edge to `resp_valid`: 3 + N cycles, where N is the number of cycles `r` stays low in WAIT.
- Store latency: 4 + N cycles.
- Unaligned error: `resp_valid` one cycle after accept.
- Back-to-back requests: at best one request per (latency+1) cycles, since IDLE is revisited each time.

## Structure
- Shared package `lc3b_mem_pkg`:
  - state enum {IDLE, MAR, MDR, WAIT, DONE};
  - constants `SIZE_BYTE`=1, `SIZE_WORD`=0, `RW_WRITE`=1.
- One natural sub-module, `mem_timeout_ctr`: loadable down-counter with a zero flag, width clog2(TIMEOUT).
- The FSM and datapath registers live in `mem_initiator`.

## Test plan
- Word load from 0x0010, memory model asserts `r` 5 cycles into WAIT with `mdr_in`=0x1234:
  - one `ldMar` pulse with `bus_out`=0x0010, `rw`=0, `datasize`=0;
  - `resp_valid` with data 0x1234, err=0, 8 cycles after accept.
- Word store 0xBEEF to 0x0020:
  - `ldMar` (0x0020), then `ldMdr` (0xBEEF) on consecutive cycles;
  - `rw`=1 through WAIT; `resp_valid` err=0; `resp_data`=0.
- Byte store wdata=0xAB7F to 0x0021:
  - `datasize`=1, `ldMdr` with `bus_out`=0x007F, completes err=0.
- Byte load, `mdr_in`=0xFF80: `resp_data`=0xFF80.
- Word load at 0x0013 (odd address): no `ldMar`; `resp_valid`+`resp_err` on the cycle after accept.
- Timeout and reset:
  - `r` held 0 with TIMEOUT=8: `resp_err`=1 exactly 8 cycles after WAIT entry;
  - separately, assert `rst` during WAIT: strobes drop immediately, no `resp_valid`, `req_ready`=1 after release.
